// File: rtl/store_buffer_if.sv
// Store buffer port bundle.
//   master: EX/MEM side. It drives the store and load requests and observes the
//           buffer status and the memory-port signals.
//   slave : the store buffer. It accepts the requests and drives the hit,
//           status and memory-port signals.
// Signal names match the memory macro's port names (addrss1, addrssw,
// write_material), so the top level can wire them straight through.
interface store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_hit_data;
    logic          mem_read;
    logic [AW-1:0] mem_addrss1;
    logic          mem_write;
    logic [AW-1:0] mem_addrssw;
    logic [DW-1:0] mem_write_material;
    logic          empty;
    logic          full;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr,
        input  st_ready, ld_hit, ld_hit_data, mem_read, mem_addrss1,
               mem_write, mem_addrssw, mem_write_material, empty, full
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr,
        output st_ready, ld_hit, ld_hit_data, mem_read, mem_addrss1,
               mem_write, mem_addrssw, mem_write_material, empty, full
    );
endinterface

// File: rtl/store_buffer.sv
// Word-granular store buffer. It sits between EX/MEM and the data memory.
//   clk   : rising-edge clock
//   rst_n : asynchronous, active-low reset. All buffered stores are discarded.
//   sb    : store_buffer_if.slave
//           - store push (st_valid/st_addr/st_data/st_ready)
//           - load search (ld_valid/ld_addr -> ld_hit/ld_hit_data)
//           - memory port (mem_read/mem_addrss1, mem_write/mem_addrssw/
//             mem_write_material)
//           - status (empty/full)
// Stores drain in program order, one per cycle, whenever no load miss needs
// the memory port. Loads forward from the youngest matching entry.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [DEPTH-1:0]         valid_q;
    logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]            count_q, count_d;

    logic          push, pop, ld_miss, hit;
    logic [DW-1:0] hit_data;
    logic [PW-1:0] idx;

    // Walk from oldest to newest so that a later (younger) match overrides
    // an earlier one. The head entry being drained this cycle still counts.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (valid_q[idx] && addr_q[idx] == sb.ld_addr) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    assign ld_miss = sb.ld_valid && !hit;
    // A load miss owns the memory port; a hit does not block the drain.
    assign pop     = (count_q != '0) && !ld_miss;
    // No pass-through when full, even if a pop frees a slot this cycle.
    assign push    = sb.st_valid && (count_q != FULL_CNT);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            data_q   <= '0;
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // While 0 < count < DEPTH, wr_ptr and rd_ptr differ. A push and a
            // pop in the same cycle therefore never touch the same slot.
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + 1'b1;
            end
            if (push) begin
                addr_q[wr_ptr_q]  <= sb.st_addr;
                data_q[wr_ptr_q]  <= sb.st_data;
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign sb.st_ready          = (count_q != FULL_CNT);
    assign sb.ld_hit            = hit;
    assign sb.ld_hit_data       = hit_data;
    assign sb.mem_read          = ld_miss;
    assign sb.mem_addrss1       = sb.ld_addr;
    // mem_write is derived from count_q, so an asynchronous reset drops it at once.
    assign sb.mem_write         = pop;
    assign sb.mem_addrssw       = addr_q[rd_ptr_q];
    assign sb.mem_write_material = data_q[rd_ptr_q];
    assign sb.empty             = (count_q == '0);
    assign sb.full              = (count_q == FULL_CNT);
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    ent_t mq[$];      // reference contents, oldest first
    ent_t pushed[$];  // every store the model accepted
    ent_t obs[$];     // every write seen on the memory port

    store_buffer_if #(.AW(32), .DW(32)) sb();
    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (.clk(clk), .rst_n(rst_n), .sb(sb));

    always #5 clk = ~clk;

    function automatic void m_hit(input logic [31:0] a, output logic h, output logic [31:0] d);
        h = 1'b0; d = '0;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].a == a) begin h = 1'b1; d = mq[i].d; end
    endfunction

    function automatic logic m_mw();
        logic h; logic [31:0] d;
        m_hit(sb.ld_addr, h, d);
        return (mq.size() != 0) && !(sb.ld_valid && !h);
    endfunction

    // Advance one clock. Model bookkeeping uses the values settled before the edge.
    task automatic cyc();
        logic h, miss, pop, push; logic [31:0] d;
        m_hit(sb.ld_addr, h, d);
        miss = sb.ld_valid && !h;
        pop  = (mq.size() != 0) && !miss && rst_n;
        push = sb.st_valid && (mq.size() < DEPTH) && rst_n;
        if (sb.mem_write) obs.push_back({sb.mem_addrssw, sb.mem_write_material});
        @(posedge clk);
        if (!rst_n) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({sb.st_addr, sb.st_data});
                pushed.push_back({sb.st_addr, sb.st_data});
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sb.st_valid = 0; sb.ld_valid = 0;
        repeat (n) cyc();
    endtask

    task automatic test_reset();
        rst_n = 0; sb.st_valid = 0; sb.st_addr = 0; sb.st_data = 0;
        sb.ld_valid = 1; sb.ld_addr = 7;
        #1;
        total++; if (sb.st_ready !== 1'b1) begin bad++; $display("FAIL rst_st_ready got=%0h exp=1", sb.st_ready); end
        total++; if (sb.empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%0h exp=1", sb.empty); end
        total++; if (sb.full !== 1'b0) begin bad++; $display("FAIL rst_full got=%0h exp=0", sb.full); end
        total++; if (sb.mem_write !== 1'b0) begin bad++; $display("FAIL rst_mem_write got=%0h exp=0", sb.mem_write); end
        total++; if (sb.mem_read !== 1'b1) begin bad++; $display("FAIL rst_mem_read got=%0h exp=1", sb.mem_read); end
        total++; if (sb.mem_addrss1 !== 32'd7) begin bad++; $display("FAIL rst_addrss1 got=%0h exp=7", sb.mem_addrss1); end
        total++; if (sb.ld_hit !== 1'b0 || sb.ld_hit_data !== 32'd0) begin bad++; $display("FAIL rst_hit got=%0h/%0h exp=0/0", sb.ld_hit, sb.ld_hit_data); end
        total++; if (sb.mem_addrssw !== 32'd0 || sb.mem_write_material !== 32'd0) begin bad++; $display("FAIL rst_head got=%0h/%0h exp=0/0", sb.mem_addrssw, sb.mem_write_material); end
        repeat (2) cyc();
        @(negedge clk); rst_n = 1; sb.ld_valid = 0; #1;
    endtask

    task automatic test_single();
        sb.st_valid = 1; sb.st_addr = 5; sb.st_data = 32'hDEADBEEF; sb.ld_valid = 0;
        cyc();
        sb.st_valid = 0;
        #1;
        total++; if (sb.mem_write !== 1'b1 || sb.mem_addrssw !== 32'd5 || sb.mem_write_material !== 32'hDEADBEEF)
            begin bad++; $display("FAIL single_write got=%0h/%0h/%0h exp=1/5/deadbeef", sb.mem_write, sb.mem_addrssw, sb.mem_write_material); end
        cyc();
        total++; if (sb.empty !== 1'b1 || sb.mem_write !== 1'b0) begin bad++; $display("FAIL single_done got=%0h/%0h exp=1/0", sb.empty, sb.mem_write); end
    endtask

    task automatic test_fill();
        sb.ld_valid = 1; sb.ld_addr = 31;
        for (int i = 0; i < 4; i++) begin
            sb.st_valid = 1; sb.st_addr = i; sb.st_data = 32'hA0 + i;
            cyc();
        end
        sb.st_valid = 0; #1;
        total++; if (sb.full !== 1'b1 || sb.st_ready !== 1'b0 || sb.mem_write !== 1'b0 || sb.mem_read !== 1'b1)
            begin bad++; $display("FAIL fill_full got=%0h/%0h/%0h/%0h exp=1/0/0/1", sb.full, sb.st_ready, sb.mem_write, sb.mem_read); end
        sb.ld_valid = 0; #1;
        for (int i = 0; i < 4; i++) begin
            total++; if (sb.mem_write !== 1'b1 || sb.mem_addrssw !== 32'(i) || sb.mem_write_material !== 32'hA0 + 32'(i))
                begin bad++; $display("FAIL fill_drain%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, sb.mem_write, sb.mem_addrssw, sb.mem_write_material, i, 32'hA0 + i); end
            cyc();
        end
        total++; if (sb.empty !== 1'b1 || sb.mem_write !== 1'b0) begin bad++; $display("FAIL fill_empty got=%0h/%0h exp=1/0", sb.empty, sb.mem_write); end
    endtask

    task automatic test_forward();
        sb.ld_valid = 1; sb.ld_addr = 99;
        sb.st_valid = 1; sb.st_addr = 3; sb.st_data = 32'h11; cyc();
        sb.st_data = 32'h22; cyc();
        sb.st_valid = 0; sb.ld_addr = 3; #1;
        total++; if (sb.ld_hit !== 1'b1 || sb.ld_hit_data !== 32'h22 || sb.mem_read !== 1'b0)
            begin bad++; $display("FAIL fwd_hit got=%0h/%0h/%0h exp=1/22/0", sb.ld_hit, sb.ld_hit_data, sb.mem_read); end
        total++; if (sb.mem_write !== 1'b1 || sb.mem_addrssw !== 32'd3 || sb.mem_write_material !== 32'h11)
            begin bad++; $display("FAIL fwd_drain got=%0h/%0h/%0h exp=1/3/11", sb.mem_write, sb.mem_addrssw, sb.mem_write_material); end
        cyc();
        total++; if (sb.ld_hit !== 1'b1 || sb.ld_hit_data !== 32'h22 || sb.mem_write_material !== 32'h22)
            begin bad++; $display("FAIL fwd_second got=%0h/%0h/%0h exp=1/22/22", sb.ld_hit, sb.ld_hit_data, sb.mem_write_material); end
        cyc();
        total++; if (sb.ld_hit !== 1'b0 || sb.ld_hit_data !== 32'd0 || sb.mem_read !== 1'b1)
            begin bad++; $display("FAIL fwd_gone got=%0h/%0h/%0h exp=0/0/1", sb.ld_hit, sb.ld_hit_data, sb.mem_read); end
        idle(2);
    endtask

    task automatic test_wrap();
        obs.delete(); pushed.delete();
        sb.ld_valid = 1; sb.ld_addr = 1000;
        for (int i = 0; i < 2; i++) begin sb.st_valid = 1; sb.st_addr = 32'h40 + i; sb.st_data = $urandom; cyc(); end
        sb.ld_valid = 0;
        for (int i = 2; i < 8; i++) begin
            sb.st_valid = 1; sb.st_addr = 32'h40 + i; sb.st_data = $urandom; #1;
            total++; if (sb.mem_write !== 1'b1 || sb.empty !== 1'b0 || sb.full !== 1'b0 || sb.st_ready !== 1'b1)
                begin bad++; $display("FAIL wrap_steady%0d got=%0h/%0h/%0h/%0h exp=1/0/0/1", i, sb.mem_write, sb.empty, sb.full, sb.st_ready); end
            cyc();
        end
        idle(3);
        total++; if (obs.size() != 8 || pushed.size() != 8) begin bad++; $display("FAIL wrap_count got=%0d exp=8", obs.size()); end
        for (int i = 0; i < obs.size() && i < pushed.size(); i++) begin
            total++; if (obs[i] !== pushed[i]) begin bad++; $display("FAIL wrap_order%0d got=%0h exp=%0h", i, obs[i], pushed[i]); end
        end
    endtask

    task automatic test_async_reset();
        obs.delete(); pushed.delete();
        sb.ld_valid = 1; sb.ld_addr = 500;
        for (int i = 0; i < 3; i++) begin sb.st_valid = 1; sb.st_addr = 32'h70 + i; sb.st_data = 32'hC0 + i; cyc(); end
        sb.st_valid = 0; sb.ld_valid = 0; #1;
        total++; if (sb.mem_write !== 1'b1) begin bad++; $display("FAIL ar_pre got=%0h exp=1", sb.mem_write); end
        #2 rst_n = 0; #1;
        total++; if (sb.mem_write !== 1'b0 || sb.empty !== 1'b1) begin bad++; $display("FAIL ar_drop got=%0h/%0h exp=0/1", sb.mem_write, sb.empty); end
        mq.delete(); obs.delete(); pushed.delete();
        @(negedge clk); @(negedge clk); rst_n = 1; #1;
        for (int i = 0; i < 5; i++) begin
            total++; if (sb.mem_write !== 1'b0 || sb.empty !== 1'b1) begin bad++; $display("FAIL ar_after%0d got=%0h/%0h exp=0/1", i, sb.mem_write, sb.empty); end
            cyc();
        end
        total++; if (obs.size() != 0) begin bad++; $display("FAIL ar_nowrite got=%0d exp=0", obs.size()); end
    endtask

    task automatic test_random();
        logic h; logic [31:0] d;
        obs.delete(); pushed.delete();
        for (int n = 0; n < 400; n++) begin
            sb.st_valid = ($urandom_range(0, 2) != 0);
            sb.st_addr  = $urandom_range(0, 7);
            sb.st_data  = $urandom;
            sb.ld_valid = ($urandom_range(0, 1) != 0);
            sb.ld_addr  = $urandom_range(0, 7);
            #1;
            m_hit(sb.ld_addr, h, d);
            total++; if (sb.ld_hit !== h || sb.ld_hit_data !== d)
                begin bad++; $display("FAIL rnd_hit@%0d got=%0h/%0h exp=%0h/%0h", n, sb.ld_hit, sb.ld_hit_data, h, d); end
            total++; if (sb.mem_read !== (sb.ld_valid && !h) || sb.mem_write !== m_mw())
                begin bad++; $display("FAIL rnd_port@%0d got=%0h/%0h exp=%0h/%0h", n, sb.mem_read, sb.mem_write, sb.ld_valid && !h, m_mw()); end
            total++; if (sb.empty !== (mq.size() == 0) || sb.full !== (mq.size() == DEPTH) || sb.st_ready !== (mq.size() != DEPTH))
                begin bad++; $display("FAIL rnd_status@%0d got=%0h/%0h/%0h size=%0d", n, sb.empty, sb.full, sb.st_ready, mq.size()); end
            if (mq.size() != 0) begin
                total++; if ({sb.mem_addrssw, sb.mem_write_material} !== mq[0])
                    begin bad++; $display("FAIL rnd_head@%0d got=%0h/%0h exp=%0h", n, sb.mem_addrssw, sb.mem_write_material, mq[0]); end
            end
            cyc();
        end
        idle(6);
        total++; if (obs.size() != pushed.size()) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", obs.size(), pushed.size()); end
        for (int i = 0; i < obs.size() && i < pushed.size(); i++) begin
            total++; if (obs[i] !== pushed[i]) begin bad++; $display("FAIL rnd_order%0d got=%0h exp=%0h", i, obs[i], pushed[i]); end
        end
    endtask

    initial begin
        sb.st_valid = 0; sb.st_addr = 0; sb.st_data = 0; sb.ld_valid = 0; sb.ld_addr = 0;
        @(negedge clk); #1;
        test_reset();
        test_single();
        test_fill();
        test_forward();
        test_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Word-granular store buffer between the EX/MEM pipeline register and the data memory. Stores from the MEM stage are queued in a small FIFO and drained to the memory write port in program order, one per cycle, whenever the memory is not servicing a load miss. Loads search the buffer; the youngest matching entry is forwarded so loads never observe stale memory. The MEM stage muxes `ld_hit_data` against the memory's `Outp1`.

## Interface

- `DEPTH`, 4: number of entries, power of two, ≥2.
- `AW`, 32: address width (word address, compared on all bits).
- `DW`, 32: data width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `st_valid`  in  1  store request from EX/MEM.
- `st_addr`  in  AW  store word address.
- `st_data`  in  DW  store data.
- `st_ready`  out  1  store accepted this cycle when high with `st_valid`.
- `ld_valid`  in  1  load request from EX/MEM.
- `ld_addr`  in  AW  load word address.
- `ld_hit`  out  1  load address matches a buffered entry.
- `ld_hit_data`  out  DW  data of youngest matching entry (0 when no hit).
- `mem_read`  out  1  to memory `read`.
- `mem_addrss1`  out  AW  to memory `addrss1`, equal to `ld_addr`.
- `mem_write`  out  1  to memory `write`.
- `mem_addrssw`  out  AW  to memory `addrssw`, head entry address.
- `mem_write_material`  out  DW  to memory `write_material`, head entry data.
- `empty`  out  1  no entries buffered (used for halt/fence).
- `full`  out  1  `DEPTH` entries buffered.

## Operation

- State: entry array (addr, data, valid), `wr_ptr`, `rd_ptr` (log2 DEPTH bits, wrap modulo DEPTH), `count` (log2 DEPTH + 1 bits, range 0..DEPTH).
- Push: `st_valid && st_ready` writes the entry at `wr_ptr`, sets valid, and increments `wr_ptr`.
- `st_ready = (count != DEPTH)`. There is no pass-through when full, even if a pop happens the same cycle.
- `ld_miss = ld_valid && !ld_hit`.
- Drain/pop: `mem_write = (count != 0) && !ld_miss`. On that edge the head entry is invalidated and `rd_ptr` is incremented.
- Memory port rule: at most one of a write and a load-miss read per cycle. Load misses take priority. A load hit does not block the drain.
- `mem_read = ld_miss`. `mem_addrss1 = ld_addr` at all times.
- Hit search: compare `ld_addr` against all valid entries. Priority goes from the newest entry (`wr_ptr-1`) back to the oldest (`rd_ptr`). The head entry being drained this cycle still participates.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged, FIFO order preserved.
- Same-cycle `st_valid` and `ld_valid`: the load sees only entries already buffered, with no bypass from `st_data`.
- `empty = (count == 0)`. `full = (count == DEPTH)`.

## Timing

- Reset: `count=0`, pointers 0, all valid bits 0. Resulting outputs:
  - `st_ready=1`, `empty=1`, `full=0`.
  - `mem_write=0`, `ld_hit=0`, `ld_hit_data=0`.
  - `mem_addrssw` and `mem_write_material` reset to 0.
  - `mem_read` follows `ld_valid`.
- Reset mid-operation: all buffered stores are discarded, and `mem_write` drops immediately (asynchronously).
- All outputs are combinational from registered state plus the current `ld_*` inputs. There is no input-to-output path from `st_*` except through the edge.
- Store latency:
  - A store accepted at edge N can appear on `mem_write` in cycle N+1 at the earliest.
  - It leaves the buffer at edge N+1 if no load miss occurs in that cycle.
  - Load-to-use on a hit: same cycle.
- Wrap-around: pointers wrap from DEPTH−1 to 0 without a bubble.
- A continuous stream of load misses stalls the drain indefinitely. This is acceptable because loads still progress.

## Test plan

- Reset: assert `rst_n=0` -> `st_ready=1`, `empty=1`, `full=0`, `mem_write=0`. With `ld_valid=1` at addr 7 -> `mem_read=1`, `mem_addrss1=7`.
- Single store of addr 5, data 0xDEADBEEF, no loads -> next cycle `mem_write=1`, `mem_addrssw=5`, `mem_write_material=0xDEADBEEF`. The cycle after that: `empty=1`, `mem_write=0`.
- Four back-to-back stores (addr 0..3, data 0xA0..0xA3) while a load misses at addr 31 -> `full=1`, `st_ready=0`, `mem_write=0`. Drop `ld_valid` -> writes to addr 0,1,2,3 in that order on consecutive cycles, then `empty=1`.
- Forwarding: store addr 3 data 0x11, then addr 3 data 0x22, while a load miss blocks the drain. Then load addr 3 -> `ld_hit=1`, `ld_hit_data=0x22`, `mem_read=0`, and `mem_write=1` for the addr 3/0x11 entry in the same cycle.
- Push with simultaneous pop at `count=2`, plus a wrap past entry DEPTH−1 -> `count` stays 2. Drained order matches push order across the wrap.
- Async reset with 3 entries buffered and `mem_write=1` -> `mem_write=0` immediately and `empty=1`. No write of those entries ever appears after `rst_n` rises.
